imem_loader: RTL

Boot-time writer for the instruction memory port that the processor fetches from. It accepts a framed byte stream (valid/ready), assembles big-endian 32-bit words and writes them to consecutive word addresses through the memory's `wea/addra/dina` port. It holds the processor (`cpu_hold`) until a complete, checksum-verified image is in memory. It sits between the host byte link and the instruction memory write port; the processor's fetch port is untouched.

---
 rtl/imem_loader_pkg.sv | 22 ++
 rtl/byte_packer.sv | 35 +++
 rtl/imem_loader.sv | 105 ++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared constants for the processor and its boot-time instruction memory loader.
// Holds memory geometry, the frame header byte and the loader state encoding.
package imem_loader_pkg;

  localparam int size    = 32;
  localparam int MemSize = 512;
  localparam logic [7:0] HEADER = 8'hA5;

  // Wide enough to hold a word count equal to MemSize itself.
  localparam int CntW = $clog2(MemSize) + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CNT_HI = 3'd1,
    CNT_LO = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

endpackage

// File: rtl/byte_packer.sv
// Shifts payload bytes MSB-first into a 32-bit word and flags the 4th byte.
// word_next is the complete word while word_done is high, so it can be registered directly.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            shift_en,
  input  logic [7:0]      data_byte,
  output logic [size-1:0] word_next,
  output logic            word_done
);

  logic [size-9:0] upper_q;
  logic [1:0]      byte_idx_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upper_q    <= '0;
      byte_idx_q <= '0;
    end else if (clear) begin
      upper_q    <= '0;
      byte_idx_q <= '0;
    end else if (shift_en) begin
      upper_q    <= {upper_q[size-17:0], data_byte};
      byte_idx_q <= byte_idx_q + 2'd1;
    end
  end

  assign word_next = {upper_q, data_byte};
  assign word_done = shift_en && (byte_idx_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: parses a framed, checksummed byte stream and writes big-endian words
// to consecutive instruction memory addresses, holding the processor until the image is good.
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [7:0]      in_data,
  output logic            in_ready,
  output logic            wea,
  output logic [size-1:0] addra,
  output logic [size-1:0] dina,
  output logic            cpu_hold,
  output logic            done,
  output logic            error
);

  state_t            state_q, state_d;
  logic [7:0]        cnt_hi_q;
  logic [7:0]        csum_q;
  logic [CntW-1:0]   count_q;
  logic [CntW-1:0]   word_idx_q;
  logic [15:0]       n_words;
  logic              accept;
  logic              start;
  logic              last_word;
  logic [size-1:0]   word_next;
  logic              word_done;

  assign in_ready = (state_q != ERR);
  assign accept   = in_valid && in_ready;
  assign n_words  = {cnt_hi_q, in_data};
  assign start    = accept && (in_data == HEADER) && ((state_q == IDLE) || (state_q == DONE));

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (start),
    .shift_en  (accept && (state_q == DATA)),
    .data_byte (in_data),
    .word_next (word_next),
    .word_done (word_done)
  );

  assign last_word = word_done && (word_idx_q == count_q - CntW'(1));

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (start) state_d = CNT_HI;
      CNT_HI: if (accept) state_d = CNT_LO;
      CNT_LO: if (accept) begin
        if (n_words > 16'(MemSize)) state_d = ERR;
        else if (n_words == 16'd0)  state_d = CSUM;
        else                        state_d = DATA;
      end
      DATA:   if (last_word) state_d = CSUM;
      CSUM:   if (accept) state_d = (in_data == csum_q) ? DONE : ERR;
      DONE:   if (start) state_d = CNT_HI;
      ERR:    state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_hi_q   <= '0;
      csum_q     <= '0;
      count_q    <= '0;
      word_idx_q <= '0;
      wea        <= 1'b0;
      addra      <= '0;
      dina       <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state_q  <= state_d;
      wea      <= 1'b0;
      // Status flags follow the next state so they change on the deciding edge.
      done     <= (state_d == DONE);
      error    <= (state_d == ERR);
      cpu_hold <= (state_d != DONE);

      if (start) begin
        csum_q     <= '0;
        word_idx_q <= '0;
      end
      if (accept && (state_q == CNT_HI)) cnt_hi_q <= in_data;
      if (accept && (state_q == CNT_LO)) count_q  <= n_words[CntW-1:0];
      if (accept && (state_q == DATA))   csum_q   <= csum_q ^ in_data;

      if (word_done) begin
        wea        <= 1'b1;
        addra      <= size'(word_idx_q);
        dina       <= word_next;
        word_idx_q <= word_idx_q + CntW'(1);
      end
    end
  end

endmodule
